spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Shares one SPI_Master_With_Single_CS byte engine between NUM_REQ requesters: init sequencer, UART command path and periodic readback poller.
- Each requester submits one 4-byte SPI transaction: addrLsb, addrMsb, dataLsb, dataMsb.
- The arbiter picks a winner by round-robin and serialises the frame LSB byte first into the engine.
- It captures the 4 MISO bytes and returns a per-requester done pulse.
- Sits between the requesters and the SPI master, replacing per-requester byte sequencers.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BYTES_PER_TXN, 4, bytes per CS-low transaction; must match engine i_TX_Count.
- GAP_CLKS, 4, idle clocks between consecutive transactions (min 1).
- TIMEOUT_CLKS, 4096, per-byte ready watchdog limit (used only with the optional feature).

Ports:
- clk40M  in  1  system clock, 40 MHz.
- nRst  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  level request per requester.
- i_frame  in  NUM_REQ*32  request frames; requester k uses bits [32k+31:32k], byte0 = bits [7:0].
- o_grant  out  NUM_REQ  one-hot; high while that requester owns the engine.
- o_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- o_rd_data  out  32  captured MISO bytes; byte0 in [7:0]; valid in the o_done cycle and held until the next o_done.
- o_err  out  1  high with o_done if the transaction aborted.
- o_busy  out  1  high in any state other than IDLE.
- o_spi_tx_byte  out  8  to engine i_TX_Byte.
- o_spi_tx_dv  out  1  to engine i_TX_DV.
- i_spi_tx_ready  in  1  from engine o_TX_Ready.
- i_spi_rx_dv  in  1  from engine o_RX_DV.
- i_spi_rx_byte  in  8  from engine o_RX_Byte.

Behaviour:
- Reset (async, nRst low):
  - All outputs are 0 and the state is IDLE.
  - Round-robin pointer = 0; byte index = 0; rx buffer = 0.
  - Reset mid-transaction abandons it with no done pulse. The engine is reset by the same nRst.
- FSM states: IDLE, GRANT, SEND, WAIT_RDY, FINISH, GAP.
- IDLE:
  - If any i_req is high, choose the first requester at or after the pointer, searching upward with wrap-around.
  - Register o_grant (one-hot) and latch that requester's 32-bit frame into an internal buffer. Go to GRANT.
- GRANT: byte index = 0; go to SEND.
- SEND:
  - o_spi_tx_dv = 1 for exactly one cycle.
  - o_spi_tx_byte = buffer byte[index]. Go to WAIT_RDY.
- WAIT_RDY:
  - Wait for the rising edge of i_spi_tx_ready (registered previous value, ready & ~ready_d).
  - On the edge: if index == BYTES_PER_TXN-1, go to FINISH; else index+1 and go to SEND.
- RX capture (any state): on each i_spi_rx_dv, store i_spi_rx_byte into rx byte[rx_index] and increment rx_index (wraps). rx_index is cleared in GRANT.
- FINISH:
  - o_done[owner] = 1 for one cycle; o_rd_data updated from the rx buffer.
  - Clear o_grant; pointer = owner+1 (mod NUM_REQ). Go to GAP.
- GAP: count GAP_CLKS cycles, then go to IDLE. Requests are ignored during GAP.
- Requester-side rules:
  - The frame is sampled only in the IDLE→GRANT cycle; later changes to i_frame are ignored.
  - Dropping i_req after grant does not cancel the transaction; done still pulses.
  - A requester holding i_req high after done is re-granted only after the others are served, if they are requesting.
- Latency: i_req high in IDLE → first o_spi_tx_dv 2 cycles later (GRANT, SEND).
- Simultaneous requests: exactly one grant; never more than one o_grant bit high.
- Ready edges arriving outside WAIT_RDY are ignored.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT_RDY.
  - If no ready edge arrives within TIMEOUT_CLKS clocks, go to FINISH with o_err = 1; o_rd_data holds the partial rx buffer.
- Without the macro: no counter, o_err is tied to 0, and WAIT_RDY waits indefinitely.

Test Plan:
- Single requester: req0 with frame 32'h0001_0030, model engine ready ≈64 clks/byte → engine receives bytes 30,00,01,00 in order; done0 pulses once; grant0 high throughout.
- All three requests held high from reset release → grants in order 0,1,2,0; each done is followed by ≥GAP_CLKS=4 idle cycles before the next tx_dv.
- MISO loopback returning A5,5A,C3,3C → o_rd_data = 32'h3C_C3_5A_A5 in the done cycle and held until the next done.
- Requester drops req and changes i_frame 1 cycle after grant → original frame still sent; done pulses to that requester.
- nRst asserted during byte 2 → all outputs 0 immediately; after release, a new req1 is granted first (pointer = 0, req0 low) and completes normally.
- With SPI_TIMEOUT_EN and TIMEOUT_CLKS=100, engine never raises ready → done pulses with o_err=1 about 100 clks after the first tx_dv; the next requester is then served.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_txn_arbiter
//
// Shares one single-CS SPI byte engine between NUM_REQ requesters. A winner
// is chosen round-robin, its 32-bit frame is latched and sent LSB byte first,
// one byte per engine ready edge. The MISO bytes are collected and returned
// with a one-cycle done pulse to the owner. GAP_CLKS idle cycles follow each
// transaction. The frame buffer is 32 bits, so BYTES_PER_TXN may be 1..4.
//
// Optional feature (macro SPI_TIMEOUT_EN): a per-byte watchdog of
// TIMEOUT_CLKS clocks in WAIT_RDY. On expiry the transaction finishes with
// o_err high and o_rd_data holding whatever was captured. Without the macro
// o_err is constant 0 and WAIT_RDY waits indefinitely.
//
// Ports:
//   clk40M          40 MHz system clock
//   nRst            asynchronous active-low reset
//   i_req           level request per requester
//   i_frame         requester k frame at [32k+31:32k], byte0 = [7:0]
//   o_grant         one-hot owner of the engine
//   o_done          one-cycle completion pulse to the owner
//   o_rd_data       captured MISO bytes, byte0 in [7:0], held between dones
//   o_err           high with o_done when the transaction timed out
//   o_busy          high whenever the FSM is not IDLE
//   o_spi_tx_byte   to engine i_TX_Byte
//   o_spi_tx_dv     to engine i_TX_DV
//   i_spi_tx_ready  from engine o_TX_Ready
//   i_spi_rx_dv     from engine o_RX_DV
//   i_spi_rx_byte   from engine o_RX_Byte
// -----------------------------------------------------------------------------
module spi_txn_arbiter #(
   parameter int NUM_REQ       = 3,
   parameter int BYTES_PER_TXN = 4,
   parameter int GAP_CLKS      = 4,
   parameter int TIMEOUT_CLKS  = 4096
) (
   input  logic                   clk40M,
   input  logic                   nRst,
   input  logic [NUM_REQ-1:0]     i_req,
   input  logic [NUM_REQ*32-1:0]  i_frame,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic [NUM_REQ-1:0]     o_done,
   output logic [31:0]            o_rd_data,
   output logic                   o_err,
   output logic                   o_busy,
   output logic [7:0]             o_spi_tx_byte,
   output logic                   o_spi_tx_dv,
   input  logic                   i_spi_tx_ready,
   input  logic                   i_spi_rx_dv,
   input  logic [7:0]             i_spi_rx_byte
);

   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX = (GAP_CLKS > TIMEOUT_CLKS) ? GAP_CLKS : TIMEOUT_CLKS;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GRANT  = 3'd1;
   localparam logic [2:0] S_SEND   = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_TXN - 1);

   logic [2:0]         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PW-1:0]      owner_q, owner_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [1:0]         idx_q, idx_d;
   logic [1:0]         rx_idx_q, rx_idx_d;
   logic [31:0]        tx_buf_q, tx_buf_d;
   logic [31:0]        rx_buf_q, rx_buf_d;
   logic [31:0]        rd_q, rd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               rdy_prev_q;
`ifdef SPI_TIMEOUT_EN
   logic               err_q, err_d;
`endif

   logic [31:0]        frames [NUM_REQ];
   logic               win_vld;
   logic [PW-1:0]      win_idx;
   logic [PW-1:0]      cand;
   int                 cand_n;
   logic               rdy_rise;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_frame
      assign frames[g] = i_frame[32*g +: 32];
   end

   // Only a low-to-high transition of ready completes a byte; a ready that
   // is simply high (engine idle) must not be mistaken for completion.
   assign rdy_rise = i_spi_tx_ready & ~rdy_prev_q;

   // Round-robin: first requester at or after the pointer, wrapping.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand_n  = 0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_n = int'(ptr_q) + i;
         if (cand_n >= NUM_REQ) cand_n = cand_n - NUM_REQ;
         cand = PW'(cand_n);
         if (!win_vld && i_req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      tx_buf_d = tx_buf_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
`ifdef SPI_TIMEOUT_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               tx_buf_d         = frames[win_idx];
               state_d          = S_GRANT;
            end
         end
         S_GRANT: begin
            idx_d   = '0;
`ifdef SPI_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = S_SEND;
         end
         S_SEND: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (rdy_rise) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_SEND;
               end
            end
`ifdef SPI_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_FINISH: begin
            rd_d    = rx_buf_q;
            grant_d = '0;
            ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            cnt_d   = '0;
            state_d = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == CW'(GAP_CLKS - 1)) state_d = S_IDLE;
            else                            cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // MISO capture runs in every state; the index restarts for each grant.
   always_comb begin
      rx_buf_d = rx_buf_q;
      rx_idx_d = rx_idx_q;
      if (state_q == S_GRANT) begin
         rx_idx_d = '0;
      end else if (i_spi_rx_dv) begin
         rx_buf_d[8*rx_idx_q +: 8] = i_spi_rx_byte;
         rx_idx_d                  = rx_idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk40M or negedge nRst) begin
      if (!nRst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         ptr_q      <= '0;
         idx_q      <= '0;
         rx_idx_q   <= '0;
         tx_buf_q   <= '0;
         rx_buf_q   <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         rdy_prev_q <= 1'b0;
`ifdef SPI_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         rx_idx_q   <= rx_idx_d;
         tx_buf_q   <= tx_buf_d;
         rx_buf_q   <= rx_buf_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         rdy_prev_q <= i_spi_tx_ready;
`ifdef SPI_TIMEOUT_EN
         err_q      <= err_d;
`endif
      end
   end

   assign o_grant       = grant_q;
   assign o_done        = (state_q == S_FINISH) ? grant_q : '0;
   // In the done cycle the live buffer is shown so the last byte, captured
   // on the same edge that entered FINISH, is already visible.
   assign o_rd_data     = (state_q == S_FINISH) ? rx_buf_q : rd_q;
   assign o_busy        = (state_q != S_IDLE);
   assign o_spi_tx_dv   = (state_q == S_SEND);
   assign o_spi_tx_byte = o_spi_tx_dv ? tx_buf_q[8*idx_q +: 8] : 8'h00;
`ifdef SPI_TIMEOUT_EN
   assign o_err         = (state_q == S_FINISH) & err_q;
`else
   assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
`timescale 1ns/1ps
module tb_spi_txn_arbiter;
   localparam int NR      = 3;
   localparam int GAP     = 4;
   localparam int TMO     = 100;
   localparam int ENG_LAT = 63;

   logic             clk40M = 1'b0;
   logic             nRst;
   logic [NR-1:0]    i_req;
   logic [NR*32-1:0] i_frame;
   logic [NR-1:0]    o_grant;
   logic [NR-1:0]    o_done;
   logic [31:0]      o_rd_data;
   logic             o_err;
   logic             o_busy;
   logic [7:0]       o_spi_tx_byte;
   logic             o_spi_tx_dv;

   logic             eng_rdy;
   logic             eng_rxdv;
   logic [7:0]       eng_rxb;
   logic             eng_busy;
   int               eng_cnt;
   int               eng_n;
   logic [7:0]       eng_pend;
   logic             eng_hang;
   logic [7:0]       miso_tab [4];

   int               cyc = 0;
   int               onehot_bad = 0;
   int               checks = 0;
   int               errors = 0;

   logic [7:0]       tx_log[$];
   int               tx_cyc[$];
   logic [NR-1:0]    tx_gnt[$];
   logic [NR-1:0]    done_vec[$];
   int               done_cyc[$];
   logic [31:0]      done_data[$];
   logic             done_err[$];

   spi_txn_arbiter #(
      .NUM_REQ(NR), .BYTES_PER_TXN(4), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk40M(clk40M), .nRst(nRst), .i_req(i_req), .i_frame(i_frame),
      .o_grant(o_grant), .o_done(o_done), .o_rd_data(o_rd_data), .o_err(o_err),
      .o_busy(o_busy), .o_spi_tx_byte(o_spi_tx_byte), .o_spi_tx_dv(o_spi_tx_dv),
      .i_spi_tx_ready(eng_rdy), .i_spi_rx_dv(eng_rxdv), .i_spi_rx_byte(eng_rxb)
   );

   always #12.5 clk40M = ~clk40M;
   always @(posedge clk40M) cyc <= cyc + 1;

   // Engine model: ready drops on tx_dv, rises ENG_LAT+1 clocks later
   // together with a one-cycle rx_dv carrying the next MISO table byte.
   always @(posedge clk40M or negedge nRst) begin
      if (!nRst) begin
         eng_rdy <= 1'b1; eng_rxdv <= 1'b0; eng_rxb <= 8'h00;
         eng_busy <= 1'b0; eng_cnt <= 0; eng_n <= 0; eng_pend <= 8'h00;
      end else begin
         eng_rxdv <= 1'b0;
         if (o_grant == '0) eng_n <= 0;
         if (o_spi_tx_dv) begin
            eng_rdy  <= 1'b0;
            eng_busy <= !eng_hang;
            eng_cnt  <= ENG_LAT;
            eng_pend <= miso_tab[eng_n];
            eng_n    <= (eng_n + 1) % 4;
         end else if (eng_busy) begin
            if (eng_cnt == 0) begin
               eng_rdy <= 1'b1; eng_busy <= 1'b0; eng_rxdv <= 1'b1; eng_rxb <= eng_pend;
            end else begin
               eng_cnt <= eng_cnt - 1;
            end
         end
      end
   end

   always @(negedge clk40M) begin
      if (nRst) begin
         if (o_spi_tx_dv) begin
            tx_log.push_back(o_spi_tx_byte);
            tx_cyc.push_back(cyc);
            tx_gnt.push_back(o_grant);
         end
         if (o_done != '0) begin
            done_vec.push_back(o_done);
            done_cyc.push_back(cyc);
            done_data.push_back(o_rd_data);
            done_err.push_back(o_err);
         end
         if ($countones(o_grant) > 1) onehot_bad++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk40M);
      #1;
   endtask

   task automatic clear_logs();
      tx_log.delete(); tx_cyc.delete(); tx_gnt.delete();
      done_vec.delete(); done_cyc.delete(); done_data.delete(); done_err.delete();
   endtask

   task automatic set_miso(input logic [31:0] v);
      for (int j = 0; j < 4; j++) miso_tab[j] = v[8*j +: 8];
   endtask

   task automatic wait_dones(input int n, input int budget, output bit ok);
      int t = 0;
      while (done_vec.size() < n && t < budget) begin tick(); t++; end
      ok = (done_vec.size() >= n);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int t = 0;
      while (o_busy !== 1'b0 && t < budget) begin tick(); t++; end
      ok = (o_busy === 1'b0);
   endtask

   function automatic logic [31:0] pack4(input int base);
      logic [31:0] v = '0;
      for (int j = 0; j < 4; j++)
         if (base + j < tx_log.size()) v[8*j +: 8] = tx_log[base + j];
      return v;
   endfunction

   task automatic test_reset();
      i_req = '0; i_frame = '0; eng_hang = 1'b0; set_miso(32'h44332211);
      nRst = 1'b0;
      repeat (3) tick();
      checks++;
      if ({o_grant, o_done, o_rd_data, o_err, o_busy, o_spi_tx_byte, o_spi_tx_dv} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got grant=%b done=%b rd=%h err=%b busy=%b byte=%h dv=%b required all 0",
                  o_grant, o_done, o_rd_data, o_err, o_busy, o_spi_tx_byte, o_spi_tx_dv);
      end
      nRst = 1'b1;
      repeat (3) tick();
      checks++;
      if (o_busy !== 1'b0 || o_grant !== '0) begin
         errors++; $display("FAIL reset_idle: busy=%b grant=%b required 0 0", o_busy, o_grant);
      end
   endtask

   task automatic test_single();
      bit ok; int c0; bit gbad;
      clear_logs();
      i_frame[31:0] = 32'h0001_0030; i_req = 3'b001; c0 = cyc;
      wait_dones(1, 2000, ok);
      i_req = '0;
      checks++;
      if (!ok) begin errors++; $display("FAIL single_wait: no done, dones=%0d required 1", done_vec.size()); end
      repeat (20) tick();
      checks++;
      if (tx_log.size() != 4) begin errors++; $display("FAIL single_tx_count: got %0d required 4", tx_log.size()); end
      checks++;
      if (pack4(0) !== 32'h0001_0030) begin errors++; $display("FAIL single_bytes: got %h required 00010030", pack4(0)); end
      checks++;
      if (tx_cyc.size() < 1 || tx_cyc[0] - c0 != 2) begin
         errors++; $display("FAIL single_latency: got %0d required 2", (tx_cyc.size() > 0) ? tx_cyc[0] - c0 : -1);
      end
      checks++;
      if (done_vec.size() != 1 || done_vec[0] !== 3'b001 || done_err[0] !== 1'b0) begin
         errors++; $display("FAIL single_done: count=%0d required 1 to requester 0 with err 0", done_vec.size());
      end
      gbad = 1'b0;
      foreach (tx_gnt[k]) if (tx_gnt[k] !== 3'b001) gbad = 1'b1;
      checks++;
      if (gbad) begin errors++; $display("FAIL single_grant: grant not 001 during a byte, required 001"); end
      wait_idle(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_idle: busy=%b required 0", o_busy); end
   endtask

   task automatic test_rr();
      bit ok;
      logic [31:0]   fr  [3];
      logic [NR-1:0] exp_own [4];
      int            own_i [4];
      fr[0] = 32'hA3A2A1A0; fr[1] = 32'hB3B2B1B0; fr[2] = 32'hC3C2C1C0;
      exp_own[0] = 3'b001; exp_own[1] = 3'b010; exp_own[2] = 3'b100; exp_own[3] = 3'b001;
      own_i[0] = 0; own_i[1] = 1; own_i[2] = 2; own_i[3] = 0;
      nRst = 1'b0;
      i_frame = {fr[2], fr[1], fr[0]}; i_req = 3'b111;
      tick(); tick();
      clear_logs();
      nRst = 1'b1;
      wait_dones(4, 4000, ok);
      i_req = '0;
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_wait: dones=%0d required 4", done_vec.size()); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (done_vec.size() <= k || done_vec[k] !== exp_own[k]) begin
            errors++; $display("FAIL rr_order%0d: got %b required %b", k, (done_vec.size() > k) ? done_vec[k] : 3'b000, exp_own[k]);
         end
         checks++;
         if (pack4(4*k) !== fr[own_i[k]]) begin
            errors++; $display("FAIL rr_frame%0d: got %h required %h", k, pack4(4*k), fr[own_i[k]]);
         end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (done_cyc.size() <= k || tx_cyc.size() <= 4*(k+1) || tx_cyc[4*(k+1)] - done_cyc[k] < GAP + 1) begin
            errors++; $display("FAIL rr_gap%0d: done-to-next-dv spacing too short, required at least %0d", k, GAP + 1);
         end
      end
      wait_idle(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_idle: busy=%b required 0", o_busy); end
   endtask

   task automatic test_loopback();
      bit ok; int t;
      clear_logs();
      set_miso(32'h3CC35AA5);
      i_frame[63:32] = 32'h0000_0042; i_req = 3'b010;
      wait_dones(1, 2000, ok);
      i_req = '0;
      checks++;
      if (!ok || done_vec[0] !== 3'b010 || done_data[0] !== 32'h3CC35AA5) begin
         errors++; $display("FAIL loop_data: got %h required 3cc35aa5 for requester 1", ok ? done_data[0] : 32'h0);
      end
      wait_idle(100, ok);
      repeat (3) tick();
      checks++;
      if (o_rd_data !== 32'h3CC35AA5) begin errors++; $display("FAIL loop_hold_idle: got %h required 3cc35aa5", o_rd_data); end
      set_miso(32'h44332211);
      i_frame[95:64] = 32'h0000_0077; i_req = 3'b100;
      t = 0;
      while (tx_log.size() < 6 && t < 1000) begin tick(); t++; end
      checks++;
      if (o_rd_data !== 32'h3CC35AA5) begin errors++; $display("FAIL loop_hold_busy: got %h required 3cc35aa5", o_rd_data); end
      wait_dones(2, 2000, ok);
      i_req = '0;
      checks++;
      if (!ok || done_vec[1] !== 3'b100 || done_data[1] !== 32'h44332211) begin
         errors++; $display("FAIL loop_data2: got %h required 44332211 for requester 2", ok ? done_data[1] : 32'h0);
      end
      wait_idle(100, ok);
   endtask

   task automatic test_frame_latch();
      bit ok;
      clear_logs();
      i_frame[31:0] = 32'hDDCCBBAA; i_req = 3'b001;
      tick();
      checks++;
      if (o_grant !== 3'b001) begin errors++; $display("FAIL latch_grant: got %b required 001", o_grant); end
      i_req = '0; i_frame[31:0] = 32'h44332211;
      wait_dones(1, 2000, ok);
      checks++;
      if (pack4(0) !== 32'hDDCCBBAA) begin errors++; $display("FAIL latch_bytes: got %h required ddccbbaa", pack4(0)); end
      checks++;
      if (!ok || done_vec[0] !== 3'b001) begin errors++; $display("FAIL latch_done: done to requester 0 missing"); end
      wait_idle(100, ok);
   endtask

   task automatic test_reset_mid();
      bit ok; int t;
      clear_logs();
      i_frame[31:0] = 32'h87654321; i_req = 3'b001;
      t = 0;
      while (tx_log.size() < 3 && t < 1000) begin tick(); t++; end
      checks++;
      if (tx_log.size() < 3) begin errors++; $display("FAIL rmid_reach: bytes sent %0d required 3", tx_log.size()); end
      i_req = '0; nRst = 1'b0;
      #1;
      checks++;
      if ({o_grant, o_done, o_rd_data, o_err, o_busy, o_spi_tx_byte, o_spi_tx_dv} !== '0) begin
         errors++; $display("FAIL rmid_outputs: grant=%b busy=%b rd=%h required all 0", o_grant, o_busy, o_rd_data);
      end
      tick(); tick();
      clear_logs();
      i_frame[63:32] = 32'h0BADF00D; i_req = 3'b010;
      nRst = 1'b1;
      tick();
      checks++;
      if (o_grant !== 3'b010) begin errors++; $display("FAIL rmid_grant: got %b required 010", o_grant); end
      wait_dones(1, 2000, ok);
      i_req = '0;
      checks++;
      if (!ok || done_vec[0] !== 3'b010 || done_err[0] !== 1'b0 || pack4(0) !== 32'h0BADF00D) begin
         errors++; $display("FAIL rmid_txn: bytes %h required 0badf00d with done to requester 1", pack4(0));
      end
      repeat (20) tick();
      checks++;
      if (done_vec.size() != 1) begin errors++; $display("FAIL rmid_done_count: got %0d required 1", done_vec.size()); end
      wait_idle(100, ok);
   endtask

`ifdef SPI_TIMEOUT_EN
   task automatic test_timeout();
      bit ok; int dt;
      clear_logs();
      eng_hang = 1'b1;
      i_frame[31:0] = 32'h11111111; i_frame[63:32] = 32'h22222222; i_req = 3'b011;
      wait_dones(1, 1000, ok);
      eng_hang = 1'b0; i_req = 3'b010;
      checks++;
      if (!ok || done_vec[0] !== 3'b001 || done_err[0] !== 1'b1) begin
         errors++; $display("FAIL tmo_done: required done to requester 0 with err 1");
      end
      dt = (ok && tx_cyc.size() > 0) ? done_cyc[0] - tx_cyc[0] : -1;
      checks++;
      if (dt < 95 || dt > 110) begin errors++; $display("FAIL tmo_delay: got %0d required about 101", dt); end
      wait_dones(2, 2000, ok);
      i_req = '0;
      checks++;
      if (!ok || done_vec[1] !== 3'b010 || done_err[1] !== 1'b0) begin
         errors++; $display("FAIL tmo_next: required done to requester 1 with err 0");
      end
      wait_idle(100, ok);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rr();
      test_loopback();
      test_frame_latch();
      test_reset_mid();
`ifdef SPI_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (onehot_bad != 0) begin errors++; $display("FAIL onehot_grant: got %0d bad cycles required 0", onehot_bad); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
